// File: rtl/mul_issue_queue.sv
// Multiply reservation station: age-ordered collapsing queue with CDB operand capture
// that issues the oldest ready op over a valid/ready handshake.
package mul_issue_queue_pkg;
  typedef struct packed {
    logic mul_signed;
    logic mul_higher;
  } mul_decode_t;
endpackage

module mul_issue_queue
  import mul_issue_queue_pkg::*;
#(
  parameter int unsigned RS_ID_WIDTH = 5,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [RS_ID_WIDTH-1:0]       disp_rs_id,
  input  logic [4:0]                   disp_result_reg_addr,
  input  mul_decode_t                  disp_control,
  input  logic                         disp_op1_present,
  input  logic [31:0]                  disp_op1_value,
  input  logic [RS_ID_WIDTH-1:0]       disp_op1_tag,
  input  logic                         disp_op2_present,
  input  logic [31:0]                  disp_op2_value,
  input  logic [RS_ID_WIDTH-1:0]       disp_op2_tag,
  input  logic                         cdb_valid,
  input  logic [RS_ID_WIDTH-1:0]       cdb_rs_id,
  input  logic [31:0]                  cdb_result,
  input  logic                         flush,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [RS_ID_WIDTH-1:0]       issue_rs_id,
  output logic [4:0]                   issue_result_reg_addr,
  output mul_decode_t                  issue_control,
  output logic [31:0]                  issue_op1,
  output logic [31:0]                  issue_op2,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = $clog2(DEPTH);

  typedef struct packed {
    logic [RS_ID_WIDTH-1:0] rs_id;
    logic [4:0]             rd;
    mul_decode_t            ctrl;
    logic                   op1_p;
    logic [31:0]            op1_v;
    logic [RS_ID_WIDTH-1:0] op1_tag;
    logic                   op2_p;
    logic [31:0]            op2_v;
    logic [RS_ID_WIDTH-1:0] op2_tag;
  } entry_t;

  entry_t          ent_q [DEPTH];
  entry_t          ent_d [DEPTH];
  entry_t          ent_s [DEPTH];
  entry_t          disp_ent;
  logic [CntW-1:0] count_q, count_d, wr_idx;
  logic            ready_q;
  logic            hold_q, hold_d;
  logic [IdxW-1:0] hold_idx_q, hold_idx_d;
  logic            sel_found;
  logic [IdxW-1:0] sel_idx;
  logic            disp_hs, issue_hs;

  assign disp_ready = ready_q && (count_q < CntW'(DEPTH));
  assign occupancy  = count_q;

  // Once presented and stalled, the same entry is held so issue fields stay stable.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    if (hold_q) begin
      sel_found = 1'b1;
      sel_idx   = hold_idx_q;
    end else begin
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if ((CntW'(i) < count_q) && ent_q[i].op1_p && ent_q[i].op2_p) begin
          sel_found = 1'b1;
          sel_idx   = IdxW'(i);
        end
      end
    end
  end

  always_comb begin
    issue_valid           = sel_found && !flush;
    issue_rs_id           = '0;
    issue_result_reg_addr = '0;
    issue_control         = '0;
    issue_op1             = '0;
    issue_op2             = '0;
    if (sel_found) begin
      issue_rs_id           = ent_q[sel_idx].rs_id;
      issue_result_reg_addr = ent_q[sel_idx].rd;
      issue_control         = ent_q[sel_idx].ctrl;
      issue_op1             = ent_q[sel_idx].op1_v;
      issue_op2             = ent_q[sel_idx].op2_v;
    end
  end

  assign disp_hs  = disp_valid && disp_ready;
  assign issue_hs = issue_valid && issue_ready;

  // CDB snoop applied to the current entries.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_s[i] = ent_q[i];
      if (cdb_valid && (CntW'(i) < count_q)) begin
        if (!ent_q[i].op1_p && (ent_q[i].op1_tag == cdb_rs_id)) begin
          ent_s[i].op1_p = 1'b1;
          ent_s[i].op1_v = cdb_result;
        end
        if (!ent_q[i].op2_p && (ent_q[i].op2_tag == cdb_rs_id)) begin
          ent_s[i].op2_p = 1'b1;
          ent_s[i].op2_v = cdb_result;
        end
      end
    end
  end

  always_comb begin
    disp_ent.rs_id   = disp_rs_id;
    disp_ent.rd      = disp_result_reg_addr;
    disp_ent.ctrl    = disp_control;
    disp_ent.op1_tag = disp_op1_tag;
    disp_ent.op2_tag = disp_op2_tag;
    disp_ent.op1_p   = disp_op1_present || (cdb_valid && (disp_op1_tag == cdb_rs_id));
    disp_ent.op2_p   = disp_op2_present || (cdb_valid && (disp_op2_tag == cdb_rs_id));
    disp_ent.op1_v   = disp_op1_present ? disp_op1_value : cdb_result;
    disp_ent.op2_v   = disp_op2_present ? disp_op2_value : cdb_result;
  end

  always_comb begin
    wr_idx = count_q - CntW'(issue_hs);
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_s[i];
    end
    if (issue_hs) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IdxW'(i) >= sel_idx) begin
          ent_d[i] = ent_s[i+1];
        end
      end
    end
    if (disp_hs) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CntW'(i) == wr_idx) begin
          ent_d[i] = disp_ent;
        end
      end
    end
    count_d    = count_q + CntW'(disp_hs) - CntW'(issue_hs);
    hold_d     = issue_valid && !issue_ready;
    hold_idx_d = sel_idx;
    if (flush) begin
      count_d = '0;
      hold_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= '0;
      ready_q    <= 1'b0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      count_q    <= count_d;
      ready_q    <= 1'b1;
      hold_q     <= hold_d;
      hold_idx_q <= hold_idx_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end
endmodule

// File: tb/tb_mul_issue_queue.sv
// Bench for mul_issue_queue: directed scenarios with literal expectations plus random
// traffic, all checked every cycle against a queue-based model.
module tb_mul_issue_queue;
  import mul_issue_queue_pkg::*;

  localparam int unsigned RSW   = 5;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            disp_valid, disp_ready;
  logic [RSW-1:0]  disp_rs_id;
  logic [4:0]      disp_result_reg_addr;
  mul_decode_t     disp_control;
  logic            disp_op1_present, disp_op2_present;
  logic [31:0]     disp_op1_value, disp_op2_value;
  logic [RSW-1:0]  disp_op1_tag, disp_op2_tag;
  logic            cdb_valid;
  logic [RSW-1:0]  cdb_rs_id;
  logic [31:0]     cdb_result;
  logic            flush;
  logic            issue_valid, issue_ready;
  logic [RSW-1:0]  issue_rs_id;
  logic [4:0]      issue_result_reg_addr;
  mul_decode_t     issue_control;
  logic [31:0]     issue_op1, issue_op2;
  logic [CW-1:0]   occupancy;

  mul_issue_queue #(.RS_ID_WIDTH(RSW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rs_id(disp_rs_id),
    .disp_result_reg_addr(disp_result_reg_addr), .disp_control(disp_control),
    .disp_op1_present(disp_op1_present), .disp_op1_value(disp_op1_value),
    .disp_op1_tag(disp_op1_tag), .disp_op2_present(disp_op2_present),
    .disp_op2_value(disp_op2_value), .disp_op2_tag(disp_op2_tag),
    .cdb_valid(cdb_valid), .cdb_rs_id(cdb_rs_id), .cdb_result(cdb_result), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rs_id(issue_rs_id),
    .issue_result_reg_addr(issue_result_reg_addr), .issue_control(issue_control),
    .issue_op1(issue_op1), .issue_op2(issue_op2), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [RSW-1:0] rs_id;
    logic [4:0]     rd;
    logic [1:0]     ctrl;
    bit             p1;
    logic [31:0]    v1;
    logic [RSW-1:0] t1;
    bit             p2;
    logic [31:0]    v2;
    logic [RSW-1:0] t2;
  } ment_t;

  ment_t q[$];
  bit    ready_m, hold_m, m_disp, m_iss, m_iv;
  int    held_m, m_sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ready_m = 1'b0;
    hold_m  = 1'b0;
    held_m  = 0;
  endtask

  // Expected outputs from model state plus current inputs; records handshakes for update().
  task automatic check_cycle();
    int sel;
    bit exp_dr, exp_iv;
    if (!rst) model_reset();
    exp_dr = ready_m && (q.size() < DEPTH);
    sel = -1;
    if (hold_m) sel = held_m;
    else foreach (q[i]) if (sel < 0 && q[i].p1 && q[i].p2) sel = i;
    exp_iv = (sel >= 0) && !flush;
    chk("disp_ready", 32'(disp_ready), 32'(exp_dr));
    chk("issue_valid", 32'(issue_valid), 32'(exp_iv));
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    if (exp_iv) begin
      chk("issue_rs_id", 32'(issue_rs_id), 32'(q[sel].rs_id));
      chk("issue_rd", 32'(issue_result_reg_addr), 32'(q[sel].rd));
      chk("issue_control", 32'({issue_control.mul_signed, issue_control.mul_higher}),
          32'(q[sel].ctrl));
      chk("issue_op1", issue_op1, q[sel].v1);
      chk("issue_op2", issue_op2, q[sel].v2);
    end
    if (!rst) begin
      chk("rst_issue_fields", issue_op1 | issue_op2 | 32'(issue_rs_id) |
          32'(issue_result_reg_addr) | 32'({issue_control.mul_signed, issue_control.mul_higher}),
          32'h0);
    end
    m_sel  = sel;
    m_iv   = exp_iv;
    m_disp = disp_valid && exp_dr;
    m_iss  = exp_iv && issue_ready;
  endtask

  task automatic update();
    ment_t e;
    if (!rst) begin
      model_reset();
      return;
    end
    ready_m = 1'b1;
    if (flush) begin
      q.delete();
      hold_m = 1'b0;
      return;
    end
    if (cdb_valid) begin
      foreach (q[i]) begin
        if (!q[i].p1 && q[i].t1 == cdb_rs_id) begin q[i].p1 = 1'b1; q[i].v1 = cdb_result; end
        if (!q[i].p2 && q[i].t2 == cdb_rs_id) begin q[i].p2 = 1'b1; q[i].v2 = cdb_result; end
      end
    end
    if (m_iss) q.delete(m_sel);
    if (m_disp) begin
      e.rs_id = disp_rs_id;
      e.rd    = disp_result_reg_addr;
      e.ctrl  = {disp_control.mul_signed, disp_control.mul_higher};
      e.t1    = disp_op1_tag;
      e.t2    = disp_op2_tag;
      e.p1    = disp_op1_present || (cdb_valid && disp_op1_tag == cdb_rs_id);
      e.p2    = disp_op2_present || (cdb_valid && disp_op2_tag == cdb_rs_id);
      e.v1    = disp_op1_present ? disp_op1_value : cdb_result;
      e.v2    = disp_op2_present ? disp_op2_value : cdb_result;
      q.push_back(e);
    end
    hold_m = m_iv && !issue_ready;
    held_m = m_sel;
  endtask

  task automatic cyc();
    #1;
    check_cycle();
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  task automatic idle();
    disp_valid = 0; disp_rs_id = '0; disp_result_reg_addr = '0; disp_control = '0;
    disp_op1_present = 0; disp_op1_value = '0; disp_op1_tag = '0;
    disp_op2_present = 0; disp_op2_value = '0; disp_op2_tag = '0;
    cdb_valid = 0; cdb_rs_id = '0; cdb_result = '0; flush = 0; issue_ready = 0;
  endtask

  task automatic disp(input int id, input bit p1, input logic [31:0] v1, input int t1,
                      input bit p2, input logic [31:0] v2, input int t2);
    disp_valid = 1; disp_rs_id = RSW'(id); disp_result_reg_addr = 5'(id + 1);
    disp_control = mul_decode_t'(2'(id));
    disp_op1_present = p1; disp_op1_value = v1; disp_op1_tag = RSW'(t1);
    disp_op2_present = p2; disp_op2_value = v2; disp_op2_tag = RSW'(t2);
  endtask

  initial begin
    idle();
    model_reset();
    @(negedge clk);
    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lit_rst_disp_ready", 32'(disp_ready), 32'h0);
      chk("lit_rst_issue_valid", 32'(issue_valid), 32'h0);
      chk("lit_rst_occupancy", 32'(occupancy), 32'h0);
      cyc();
    end
    rst = 1;
    cyc();
    #1 chk("lit_ready_after_rst", 32'(disp_ready), 32'h1);

    // Ready dispatch
    disp(3, 1, 32'd7, 0, 1, 32'd6, 0);
    cyc();
    disp_valid = 0;
    #1;
    chk("lit_ready_iv", 32'(issue_valid), 32'h1);
    chk("lit_ready_op1", issue_op1, 32'd7);
    chk("lit_ready_op2", issue_op2, 32'd6);
    chk("lit_ready_rs", 32'(issue_rs_id), 32'd3);
    issue_ready = 1;
    cyc();
    #1 chk("lit_ready_occ", 32'(occupancy), 32'h0);

    // Wakeup: younger ready op passes older blocked one
    issue_ready = 0;
    disp(1, 1, 32'd2, 0, 0, 32'd0, 9);
    cyc();
    disp(2, 1, 32'd3, 0, 1, 32'd4, 0);
    cyc();
    disp_valid = 0;
    #1 chk("lit_wake_b_first", 32'(issue_rs_id), 32'd2);
    issue_ready = 1;
    cyc();
    cdb_valid = 1; cdb_rs_id = 5'd9; cdb_result = 32'hFFFF_FFFE;
    #1 chk("lit_wake_not_yet", 32'(issue_valid), 32'h0);
    cyc();
    cdb_valid = 0;
    #1;
    chk("lit_wake_a_rs", 32'(issue_rs_id), 32'd1);
    chk("lit_wake_a_op2", issue_op2, 32'hFFFF_FFFE);
    cyc();

    // Full queue under backpressure
    issue_ready = 0;
    for (int k = 0; k < DEPTH; k++) begin
      disp(10 + k, 1, 32'(k), 0, 1, 32'(k + 1), 0);
      cyc();
    end
    disp(14, 1, 32'd99, 0, 1, 32'd98, 0);
    #1;
    chk("lit_full_disp_ready", 32'(disp_ready), 32'h0);
    chk("lit_full_head", 32'(issue_rs_id), 32'd10);
    cyc();
    disp_valid = 0; issue_ready = 1;
    for (int k = 0; k < DEPTH; k++) begin
      #1 chk("lit_drain_order", 32'(issue_rs_id), 32'(10 + k));
      cyc();
    end
    #1 chk("lit_drain_occ", 32'(occupancy), 32'h0);

    // Dispatch bypass from CDB
    issue_ready = 0;
    disp(20, 0, 32'd0, 4, 1, 32'd5, 0);
    cdb_valid = 1; cdb_rs_id = 5'd4; cdb_result = 32'h10;
    cyc();
    disp_valid = 0; cdb_valid = 0;
    #1 chk("lit_bypass_op1", issue_op1, 32'h10);
    issue_ready = 1;
    cyc();

    // Simultaneous dispatch and issue at occupancy 2
    issue_ready = 0;
    disp(21, 1, 32'd1, 0, 1, 32'd1, 0); cyc();
    disp(22, 1, 32'd2, 0, 1, 32'd2, 0); cyc();
    disp(23, 1, 32'd3, 0, 1, 32'd3, 0);
    issue_ready = 1;
    #1 chk("lit_simul_before", 32'(occupancy), 32'd2);
    cyc();
    disp_valid = 0;
    #1 chk("lit_simul_after", 32'(occupancy), 32'd2);
    cyc(); cyc();

    // Flush with one issuable entry
    issue_ready = 0;
    disp(8, 0, 32'd0, 30, 1, 32'd1, 0); cyc();
    disp(9, 1, 32'd1, 0, 0, 32'd0, 31); cyc();
    disp(7, 1, 32'd5, 0, 1, 32'd6, 0); cyc();
    disp_valid = 0;
    #1 chk("lit_flush_pre_iv", 32'(issue_valid), 32'h1);
    flush = 1;
    #1 chk("lit_flush_iv", 32'(issue_valid), 32'h0);
    cyc();
    flush = 0;
    #1 chk("lit_flush_occ", 32'(occupancy), 32'h0);
    issue_ready = 1; cdb_valid = 1; cdb_rs_id = 5'd30; cdb_result = 32'h1;
    cyc();
    cdb_rs_id = 5'd31;
    cyc();
    cdb_valid = 0;
    #1 chk("lit_flush_no_stale", 32'(issue_valid), 32'h0);
    cyc();

    // Random traffic with a mid-run asynchronous reset
    for (int i = 0; i < 1500; i++) begin
      rst = !(i >= 700 && i < 702);
      disp_valid = ($urandom_range(0, 1) == 1);
      disp_rs_id = RSW'($urandom_range(0, 31));
      disp_result_reg_addr = 5'($urandom);
      disp_control = mul_decode_t'(2'($urandom));
      disp_op1_present = ($urandom_range(0, 1) == 1);
      disp_op1_value = $urandom;
      disp_op1_tag = RSW'($urandom_range(0, 7));
      disp_op2_present = ($urandom_range(0, 1) == 1);
      disp_op2_value = $urandom;
      disp_op2_tag = RSW'($urandom_range(0, 7));
      cdb_valid = ($urandom_range(0, 1) == 1);
      cdb_rs_id = RSW'($urandom_range(0, 7));
      cdb_result = $urandom;
      flush = ($urandom_range(0, 24) == 0);
      issue_ready = ($urandom_range(0, 9) < 6);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
